conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
- Streaming 3x3 convolution stage that sits directly upstream of the 2x2 max-pooling stage.
- Consumes a raster-order signed 8-bit image and produces a same-size map of 22-bit signed results in raster order (zero "same" padding).
- The output stream connects straight to the pooling stage's pixel_in/pixel_valid/start_signal.
- Kernel weights are written through a small register port while the block is idle.

Parameters:
- IMG_WIDTH, 32, pixels per row (W).
- IMG_HEIGHT, 32, rows per frame (H).
- PIX_W, 8, signed input pixel and weight width.
- OUT_W, 22, signed result width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start_signal  in  1  starts a frame; honoured only in IDLE.
- pixel_in  in  PIX_W  signed input pixel.
- pixel_valid  in  1  pixel_in is valid.
- pixel_ready  out  1  block accepts pixel_in this cycle.
- weight_we  in  1  weight write strobe.
- weight_addr  in  4  kernel index k = 3*row + col (row 0 = top, col 0 = left); 9..15 ignored.
- weight_data  in  PIX_W  signed weight.
- result_out  out  OUT_W  signed convolution result.
- result_valid  out  1  result_out is valid, one-cycle strobe per result.
- done_signal  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst=0, async): state=IDLE; counters 0; weights 0; result_out=0, result_valid=0, pixel_ready=0, done_signal=0. Line buffers are not reset; masking makes stale contents invisible. Reset mid-frame aborts the frame with no further outputs.
- States and transitions:
  - IDLE -> PROCESSING on start_signal.
  - PROCESSING -> FLUSH after consuming element (W, H-1).
  - FLUSH -> DONE after consuming element (W, H).
  - DONE -> IDLE unconditionally.
  - start_signal outside IDLE is ignored.
- Extended raster:
  - Counters ex in 0..W, ey in 0..H.
  - Real element: ex<W and ey<H. It is consumed when pixel_valid && pixel_ready. pixel_ready = (state==PROCESSING && ex<W).
  - Virtual zero element: ex==W (PROCESSING) or any ex in FLUSH. It is consumed automatically, one per cycle, with pixel_ready=0.
  - Counters advance only on consumption, ex first, wrapping at W.
  - Total consumed per frame = (W+1)*(H+1) = 1089 at default parameters.
- Window:
  - Every consumed element is written into two line buffers of depth W+1 and a 3-deep column shift register.
  - When (ex,ey) is consumed with ex>=1 and ey>=1, the window is centred on output (ex-1, ey-1) over columns ex-2..ex and rows ey-2..ey.
  - Taps at column -1 (ex==1) or row -1 (ey==1) are forced to 0.
  - Output count is exactly W*H, in raster order.
- Arithmetic:
  - Nine signed PIX_W x PIX_W products (2*PIX_W bits each) are summed at full precision and sign-extended to OUT_W.
  - No saturation is needed (|sum| <= 147456).
- Latency: result_out/result_valid are registered and appear 1 cycle after the consuming cycle. result_valid is 0 in all other cycles.
- done_signal = (state==DONE). It coincides with the final result_valid.
- Weights: weight_we is honoured only in IDLE; writes in any other state are dropped. Weights are stable for the whole frame.
- Input gaps (pixel_valid low) stall real consumption only. Virtual elements proceed regardless of pixel_valid.

Optional Feature:
- Macro: CONV3X3_RELU_EN.
- Defined: negative sums are output as 0 (ReLU) before registering; latency is unchanged.
- Undefined: the raw signed sum is output.

Test Plan:
- Identity kernel (w4=1, rest 0), pixel=(x+y)&0x7F -> 1024 results equal to input in raster order; done_signal coincides with the 1024th result_valid.
- All weights 1, all pixels 1 -> corners 4, edge pixels 6, interior 9; exactly 1024 results.
- All pixels -128, all weights 127 -> interior -146304, corner -65024, edge -97536. With CONV3X3_RELU_EN defined, all results are 0.
- pixel_valid held high -> pixel_ready drops for exactly 1 cycle after every 32 accepted pixels; FLUSH lasts 33 cycles; 1089 consumption cycles from start to DONE.
- Random pixel_valid gaps (~30%) with the identity kernel -> results bit-identical to the first scenario; no result is emitted while pixel_valid is low in PROCESSING, except those triggered by virtual-column cycles.
- Assert rst after 500 accepted pixels, then run a full frame; also write a weight during PROCESSING -> after reset, a full correct frame with weights at 0 (all results 0); the mid-frame weight write has no effect.

Source files
------------

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 "same"-padded convolution of a raster-order signed image.
// Optional ReLU on the output when CONV3X3_RELU_EN is defined (default build: raw signed sum).
// Ports:
//   clk, rst (async, active-low)
//   start_signal                      - starts a frame, honoured only in IDLE
//   pixel_in/pixel_valid/pixel_ready  - input pixel handshake
//   weight_we/weight_addr/weight_data - kernel write port (k = 3*row + col), IDLE only
//   result_out/result_valid           - registered convolution result strobe
//   done_signal                       - one-cycle pulse coinciding with the last result
module conv3x3_stream #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int PIX_W      = 8,
    parameter int OUT_W      = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_signal,
    input  logic signed [PIX_W-1:0] pixel_in,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    input  logic                    weight_we,
    input  logic [3:0]              weight_addr,
    input  logic signed [PIX_W-1:0] weight_data,
    output logic signed [OUT_W-1:0] result_out,
    output logic                    result_valid,
    output logic                    done_signal
);
    localparam int XW = $clog2(IMG_WIDTH + 1);
    localparam int YW = $clog2(IMG_HEIGHT + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT);
    localparam logic [YW-1:0] Y_PRE  = YW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, PROC, FLUSH, DONE} state_t;

    state_t                    r_state, w_next;
    logic [XW-1:0]             r_ex;
    logic [YW-1:0]             r_ey;
    logic signed [PIX_W-1:0]   r_w   [9];
    logic signed [PIX_W-1:0]   r_lb1 [IMG_WIDTH+1];
    logic signed [PIX_W-1:0]   r_lb2 [IMG_WIDTH+1];
    logic signed [PIX_W-1:0]   r_c1  [3];
    logic signed [PIX_W-1:0]   r_c2  [3];
    logic signed [OUT_W-1:0]   r_result;
    logic                      r_valid;
    logic                      w_consume, w_row_end, w_emit;
    logic signed [PIX_W-1:0]   w_pix;
    logic signed [PIX_W-1:0]   w_col  [3];
    logic signed [PIX_W-1:0]   w_win  [9];
    logic signed [2*PIX_W-1:0] w_prod [9];
    logic signed [OUT_W-1:0]   w_sum, w_res;

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start_signal ? PROC : IDLE;
            PROC:    w_next = (w_consume && w_row_end && r_ey == Y_PRE) ? FLUSH : PROC;
            FLUSH:   w_next = w_row_end ? DONE : FLUSH;
            default: w_next = IDLE;
        endcase
    end

    // The column at ex==W and every FLUSH element are virtual zeros consumed without a handshake.
    always_comb begin
        w_row_end   = r_ex == X_LAST;
        pixel_ready = r_state == PROC && !w_row_end;
        done_signal = r_state == DONE;
        w_consume   = (r_state == PROC && (w_row_end || pixel_valid)) || r_state == FLUSH;
        w_pix       = pixel_ready ? pixel_in : '0;
        w_emit      = w_consume && r_ex != '0 && r_ey != '0;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_ex <= '0;
            r_ey <= '0;
        end else if (w_consume) begin
            r_ex <= w_row_end ? '0 : r_ex + 1'b1;
            if (w_row_end) r_ey <= (r_ey == Y_LAST) ? '0 : r_ey + 1'b1;
        end

    // Storage below is deliberately unreset: the edge masks hide anything stale.
    always_ff @(posedge clk)
        if (w_consume) begin
            r_lb1[r_ex] <= w_pix;
            r_lb2[r_ex] <= r_lb1[r_ex];
            for (int r = 0; r < 3; r++) begin
                r_c1[r] <= w_col[r];
                r_c2[r] <= r_c1[r];
            end
        end

    // Window rows: 0 = ey-2 (top), 1 = ey-1, 2 = ey; columns: 0 = ex-2 (left), 1 = ex-1, 2 = ex.
    always_comb begin
        w_col[0] = r_lb2[r_ex];
        w_col[1] = r_lb1[r_ex];
        w_col[2] = w_pix;
        for (int r = 0; r < 3; r++) begin
            w_win[3*r]   = (r_ex == XW'(1) || (r == 0 && r_ey == YW'(1))) ? '0 : r_c2[r];
            w_win[3*r+1] = (r == 0 && r_ey == YW'(1)) ? '0 : r_c1[r];
            w_win[3*r+2] = (r == 0 && r_ey == YW'(1)) ? '0 : w_col[r];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = r_w[k] * w_win[k];
            w_sum     = w_sum + OUT_W'(w_prod[k]);
        end
`ifdef CONV3X3_RELU_EN
        w_res = w_sum[OUT_W-1] ? '0 : w_sum;
`else
        w_res = w_sum;
`endif
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) r_result <= w_res;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int k = 0; k < 9; k++) r_w[k] <= '0;
        end else if (r_state == IDLE && weight_we && weight_addr < 4'd9) begin
            r_w[weight_addr] <= weight_data;
        end

    assign result_out   = r_result;
    assign result_valid = r_valid;
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: directed frame-level bench for conv3x3_stream with a reference convolution model.
module tb_conv3x3_stream;
    localparam int W = 32;
    localparam int H = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start_signal = 1'b0;
    logic signed [7:0]  pixel_in = '0;
    logic               pixel_valid = 1'b0;
    logic               pixel_ready;
    logic               weight_we = 1'b0;
    logic [3:0]         weight_addr = '0;
    logic signed [7:0]  weight_data = '0;
    logic signed [21:0] result_out;
    logic               result_valid;
    logic               done_signal;

    int passed = 0;
    int total  = 0;
    int kw [9];
    int mode;
    int res [1100];
    int n, done_n, bad;
    logic prev_pv = 1'b0, prev_pr = 1'b0;

    always #5 clk = ~clk;

    conv3x3_stream dut (
        .clk(clk), .rst(rst), .start_signal(start_signal),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .weight_we(weight_we), .weight_addr(weight_addr), .weight_data(weight_data),
        .result_out(result_out), .result_valid(result_valid), .done_signal(done_signal)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    endtask

    function automatic int pix(input int x, input int y);
        if (x < 0 || y < 0 || x >= W || y >= H) return 0;
        if (mode == 0) return (x + y) & 127;
        if (mode == 1) return 1;
        return -128;
    endfunction

    function automatic int model(input int x, input int y);
        int s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                s += kw[(dy + 1) * 3 + dx + 1] * pix(x + dx, y + dy);
`ifdef CONV3X3_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    always @(negedge clk) begin
        if (result_valid) begin
            if (n < 1100) res[n] = result_out;
            n++;
            if (prev_pr && !prev_pv) bad++;
        end
        if (done_signal) done_n = result_valid ? n : -2;
        prev_pv = pixel_valid;
        prev_pr = pixel_ready;
    end

    task automatic wr(input int a, input int d);
        @(posedge clk); #1;
        weight_we = 1'b1; weight_addr = 4'(a); weight_data = 8'(d);
        @(posedge clk); #1;
        weight_we = 1'b0;
        kw[a] = d;
    endtask

    task automatic run_frame(input bit gap, input bit wmid, input int abort_at,
                             output int cyc, output int acc_n, output int low_n, output int first_low);
        int px = 0, py = 0;
        logic acc;
        cyc = 0; acc_n = 0; low_n = 0; first_low = -1;
        n = 0; bad = 0; done_n = -1;
        @(posedge clk); #1 start_signal = 1'b1;
        @(posedge clk); #1 start_signal = 1'b0;
        while (cyc < 5000) begin
            if (done_signal) break;
            cyc++;
            pixel_valid = gap ? ($urandom_range(0, 9) >= 3) : 1'b1;
            pixel_in = 8'(pix(px, py));
            if (!pixel_ready) begin
                low_n++;
                if (first_low < 0) first_low = acc_n;
            end
            acc = pixel_valid && pixel_ready;
            weight_we = wmid && cyc == 100;
            weight_addr = 4'd4; weight_data = 8'sd3;
            @(posedge clk); #1;
            if (acc) begin
                acc_n++;
                px++;
                if (px == W) begin px = 0; py++; end
                if (abort_at > 0 && acc_n == abort_at) break;
            end
        end
        pixel_valid = 1'b0;
        weight_we = 1'b0;
        if (abort_at == 0) check("frame_done_reached", done_signal, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_count"}, n, W * H);
        check({tag, "_done_with_last"}, done_n, W * H);
        for (int i = 0; i < W * H; i++)
            check($sformatf("%s[%0d]", tag, i), res[i], model(i % W, i / W));
    endtask

    initial begin
        int cyc, acc_n, low_n, first_low;
        for (int k = 0; k < 9; k++) kw[k] = 0;
        mode = 0; n = 0; bad = 0; done_n = -1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result_valid", result_valid, 0);
        check("rst_result_out", result_out, 0);
        check("rst_pixel_ready", pixel_ready, 0);
        check("rst_done", done_signal, 0);
        rst = 1'b1;

        // identity kernel, continuous input
        mode = 0;
        wr(4, 1);
        run_frame(1'b0, 1'b0, 0, cyc, acc_n, low_n, first_low);
        check("ident_cycles", cyc, 1089);
        check("ident_accepted", acc_n, 1024);
        check("ident_ready_low", low_n, 65);
        check("ident_first_low_after", first_low, 32);
        check_frame("ident");

        // all ones
        mode = 1;
        for (int k = 0; k < 9; k++) wr(k, 1);
        run_frame(1'b0, 1'b0, 0, cyc, acc_n, low_n, first_low);
        check_frame("ones");
        check("ones_corner", res[0], 4);
        check("ones_edge", res[1], 6);
        check("ones_interior", res[W + 1], 9);
        check("ones_last_corner", res[W * H - 1], 4);

        // extreme magnitudes
        mode = 2;
        for (int k = 0; k < 9; k++) wr(k, 127);
        run_frame(1'b0, 1'b0, 0, cyc, acc_n, low_n, first_low);
        check_frame("extreme");
`ifdef CONV3X3_RELU_EN
        check("extreme_corner", res[0], 0);
        check("extreme_edge", res[1], 0);
        check("extreme_interior", res[W + 1], 0);
`else
        check("extreme_corner", res[0], -65024);
        check("extreme_edge", res[1], -97536);
        check("extreme_interior", res[W + 1], -146304);
`endif

        // identity with random gaps and a dropped mid-frame weight write
        mode = 0;
        for (int k = 0; k < 9; k++) wr(k, k == 4 ? 1 : 0);
        run_frame(1'b1, 1'b1, 0, cyc, acc_n, low_n, first_low);
        check("gaps_accepted", acc_n, 1024);
        check("gaps_no_result_on_idle_input", bad, 0);
        check_frame("gaps");

        // abort by reset after 500 pixels, then a full frame with cleared weights
        run_frame(1'b0, 1'b1, 500, cyc, acc_n, low_n, first_low);
        check("abort_accepted", acc_n, 500);
        rst = 1'b0;
        #1;
        check("abort_pixel_ready", pixel_ready, 0);
        check("abort_result_valid", result_valid, 0);
        check("abort_done", done_signal, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n = 0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_outputs", n, 0);
        for (int k = 0; k < 9; k++) kw[k] = 0;
        run_frame(1'b0, 1'b0, 0, cyc, acc_n, low_n, first_low);
        check("post_reset_cycles", cyc, 1089);
        check_frame("post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
